// File: rtl/exec_pkg.sv
// Shared definitions for the 8-bit MIPS execute stage.
// Contents: default widths, op encodings (3-bit op field) and the
// execute FSM state type.
package exec_pkg;

  localparam int unsigned DEF_WIDTH      = 8;
  localparam int unsigned DEF_REG_ADDR_W = 5;

  typedef enum logic [2:0] {
    OP_ADD   = 3'b000,
    OP_SUB   = 3'b001,
    OP_AND   = 3'b010,
    OP_OR    = 3'b011,
    OP_SLT   = 3'b100,
    OP_MULTU = 3'b101,
    OP_DIVU  = 3'b110,
    OP_NOR   = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/muldiv_seq.sv
// Iterative unsigned multiplier / restoring divider, one step per cycle.
// Ports:
//   clk, reset_n          clock, async active-low reset
//   start                 load operands and begin (op_div selects divide)
//   operand_a, operand_b  multiplicand/dividend, multiplier/divisor
//   done                  high during the cycle whose step is the last one
//   lo, hi                result after the current step:
//                         product low/high, or quotient/remainder
module muldiv_seq
  import exec_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned ITER  = WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             op_div,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             done,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);

  localparam int unsigned CNT_W = $clog2(ITER + 1);

  // Both algorithms share one 2*WIDTH accumulator:
  //   multiply: {partial product, remaining multiplier bits}
  //   divide:   {partial remainder, dividend bits becoming quotient bits}
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   b_q;
  logic               div_q;
  logic               run_q;
  logic [CNT_W-1:0]   cnt_q;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic               div_fit;
  logic [WIDTH-1:0]   rem_next;

  always_comb begin
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
    div_shift = acc_q[2*WIDTH-1:WIDTH-1];
    div_fit   = (div_shift >= {1'b0, b_q});
    rem_next  = div_fit ? WIDTH'(div_shift - {1'b0, b_q}) : div_shift[WIDTH-1:0];
    if (div_q) begin
      acc_d = {rem_next, acc_q[WIDTH-2:0], div_fit};
    end else begin
      acc_d = {mul_sum, acc_q[WIDTH-1:1]};
    end
  end

  assign done = run_q && (cnt_q == CNT_W'(ITER - 1));
  assign lo   = acc_d[WIDTH-1:0];
  assign hi   = acc_d[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q <= '0;
      b_q   <= '0;
      div_q <= 1'b0;
      run_q <= 1'b0;
      cnt_q <= '0;
    end else if (start) begin
      acc_q <= {{WIDTH{1'b0}}, operand_a};
      b_q   <= operand_b;
      div_q <= op_div;
      run_q <= 1'b1;
      cnt_q <= '0;
    end else if (run_q) begin
      acc_q <= acc_d;
      cnt_q <= done ? '0 : cnt_q + 1'b1;
      if (done) begin
        run_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/exec_unit.sv
// 8-bit MIPS execute stage feeding the register bank write port.
// Ports:
//   clk, reset_n              clock, async active-low reset
//   in_valid / in_ready       operation handshake (ready only in IDLE)
//   op                        ADD SUB AND OR SLT MULTU DIVU NOR
//   operand_a, operand_b      bank read data
//   dest_reg                  destination register index
//   write, write_data,
//   write_register            write-back triple (write is a 1-cycle strobe)
//   hi_out                    HI register (MULTU high byte / DIVU remainder)
//   busy                      multi-cycle op iterating
//   div_by_zero               pulses with write for a DIVU by zero
module exec_unit
  import exec_pkg::*;
#(
  parameter int unsigned WIDTH      = DEF_WIDTH,
  parameter int unsigned REG_ADDR_W = DEF_REG_ADDR_W,
  parameter int unsigned ITER       = WIDTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            op,
  input  logic [WIDTH-1:0]      operand_a,
  input  logic [WIDTH-1:0]      operand_b,
  input  logic [REG_ADDR_W-1:0] dest_reg,
  output logic                  write,
  output logic [WIDTH-1:0]      write_data,
  output logic [REG_ADDR_W-1:0] write_register,
  output logic [WIDTH-1:0]      hi_out,
  output logic                  busy,
  output logic                  div_by_zero
);

  state_e                state_q, state_d;
  logic                  write_q, write_d;
  logic [WIDTH-1:0]      wdata_q, wdata_d;
  logic [REG_ADDR_W-1:0] wreg_q, wreg_d;
  logic [WIDTH-1:0]      hi_q, hi_d;
  logic                  dbz_q, dbz_d;
  logic                  dbz_pend_q, dbz_pend_d;

  logic                  md_start;
  logic                  md_done;
  logic [WIDTH-1:0]      md_lo, md_hi;
  logic [WIDTH-1:0]      alu_res;

  muldiv_seq #(
    .WIDTH (WIDTH),
    .ITER  (ITER)
  ) u_muldiv (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (md_start),
    .op_div    (op == OP_DIVU),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .done      (md_done),
    .lo        (md_lo),
    .hi        (md_hi)
  );

  always_comb begin
    alu_res = '0;
    case (op)
      OP_ADD: alu_res = operand_a + operand_b;
      OP_SUB: alu_res = operand_a - operand_b;
      OP_AND: alu_res = operand_a & operand_b;
      OP_OR:  alu_res = operand_a | operand_b;
      OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(operand_a) < $signed(operand_b))};
      OP_NOR: alu_res = ~(operand_a | operand_b);
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    write_d    = 1'b0;
    wdata_d    = wdata_q;
    wreg_d     = wreg_q;
    hi_d       = hi_q;
    dbz_d      = 1'b0;
    dbz_pend_d = dbz_pend_q;
    md_start   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          wreg_d = dest_reg;
          if (op == OP_MULTU) begin
            state_d  = S_MUL;
            md_start = 1'b1;
          end else if (op == OP_DIVU) begin
            state_d    = S_DIV;
            md_start   = 1'b1;
            dbz_pend_d = (operand_b == '0);
          end else begin
            wdata_d = alu_res;
            write_d = (dest_reg != '0);
          end
        end
      end
      // Results are captured on the final step's edge so that the
      // write strobe and hi_out are valid throughout the DONE cycle.
      S_MUL, S_DIV: begin
        if (md_done) begin
          state_d = S_DONE;
          write_d = (wreg_q != '0);
          wdata_d = md_lo;
          hi_d    = md_hi;
          dbz_d   = (state_q == S_DIV) && dbz_pend_q;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      write_q    <= 1'b0;
      wdata_q    <= '0;
      wreg_q     <= '0;
      hi_q       <= '0;
      dbz_q      <= 1'b0;
      dbz_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      write_q    <= write_d;
      wdata_q    <= wdata_d;
      wreg_q     <= wreg_d;
      hi_q       <= hi_d;
      dbz_q      <= dbz_d;
      dbz_pend_q <= dbz_pend_d;
    end
  end

  assign in_ready       = (state_q == S_IDLE);
  assign busy           = (state_q == S_MUL) || (state_q == S_DIV);
  assign write          = write_q;
  assign write_data     = wdata_q;
  assign write_register = wreg_q;
  assign hi_out         = hi_q;
  assign div_by_zero    = dbz_q;

endmodule
